vscale_htif_host: RTL and testbench

Synthesizable HTIF host that drives the core's PCR request/response port from the host side. It periodically reads the `to_host` CSR and, on a nonzero value, acknowledges by writing zero back. It then latches a sticky pass/fail/timeout verdict. It replaces the behavioural polling in simulation benches and sits between `vscale_sim_top`'s `htif_pcr_*` port and board-level status pins.

---
 rtl/vscale_htif_host_pkg.sv | 27 ++
 rtl/vscale_sat_counter.sv | 35 +++
 rtl/vscale_htif_host.sv | 150 +++++++++++++++
 tb/tb_vscale_htif_host.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_host_pkg.sv
// Shared constants, state encodings and verdict record for the HTIF host poller.
// Imported by the host FSM top and its bench-facing users.
package vscale_htif_host_pkg;

  localparam int          HTIF_PCR_WIDTH   = 64;
  localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;

  localparam logic HTIF_HOST_RW_READ  = 1'b0;
  localparam logic HTIF_HOST_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_GAP     = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } host_state_e;

  typedef struct packed {
    logic done;
    logic pass;
    logic fail;
    logic timeout;
  } verdict_t;

endpackage

// File: rtl/vscale_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
// Count is registered: the value moves one cycle after en is sampled high.
module vscale_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vscale_htif_host.sv
// Polls to_host over the PCR port, acks nonzero values with a zero write, latches a sticky verdict.
// All outputs registered; requests hold until req_ready, responses are taken only in a *_RESP state.
module vscale_htif_host
  import vscale_htif_host_pkg::*;
#(
  parameter int          PCR_WIDTH  = HTIF_PCR_WIDTH,
  parameter int unsigned POLL_GAP   = 8,
  parameter int unsigned MAX_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 htif_pcr_req_valid,
  input  logic                 htif_pcr_req_ready,
  output logic                 htif_pcr_req_rw,
  output logic [11:0]          htif_pcr_req_addr,
  output logic [PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                 htif_pcr_resp_valid,
  output logic                 htif_pcr_resp_ready,
  input  logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [30:0]          fail_code,
  output logic [31:0]          cycle_count
);

  localparam int          GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam bit          TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam logic [31:0] MAX_CYC32  = 32'(MAX_CYCLES);

  host_state_e state_q, state_d;
  verdict_t    verdict_q, verdict_d;
  logic [31:0] cap_q, cap_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        req_valid_q, req_valid_d;
  logic        req_rw_q, req_rw_d;
  logic        resp_ready_q, resp_ready_d;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0] cycle_cnt;

  vscale_sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .en      (1'b1),
    .cnt     (cycle_cnt)
  );

  // Counts only while idling; any other state holds it at zero so each GAP starts fresh.
  vscale_sat_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != ST_GAP),
    .en      (state_q == ST_GAP),
    .cnt     (gap_cnt)
  );

  always_comb begin
    state_d     = state_q;
    verdict_d   = verdict_q;
    cap_d       = cap_q;
    fail_code_d = fail_code_q;

    unique case (state_q)
      ST_GAP: begin
        if (TIMEOUT_EN && (cycle_cnt >= MAX_CYC32)) begin
          state_d           = ST_DONE;
          verdict_d.done    = 1'b1;
          verdict_d.timeout = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (htif_pcr_req_ready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (htif_pcr_resp_valid) begin
          // Upper bits count towards "nonzero" but only the low word is decoded.
          if (|htif_pcr_resp_data) begin
            cap_d   = htif_pcr_resp_data[31:0];
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_WR_REQ: begin
        if (htif_pcr_req_ready) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (htif_pcr_resp_valid) begin
          state_d        = ST_DONE;
          verdict_d.done = 1'b1;
          if (cap_q == 32'd1) begin
            verdict_d.pass = 1'b1;
          end else begin
            verdict_d.fail = 1'b1;
            fail_code_d    = cap_q[31:1];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_GAP;
      end
    endcase

    req_valid_d  = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    req_rw_d     = (state_d == ST_WR_REQ) ? HTIF_HOST_RW_WRITE : HTIF_HOST_RW_READ;
    resp_ready_d = (state_d == ST_RD_RESP) || (state_d == ST_WR_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_GAP;
      verdict_q    <= '0;
      cap_q        <= '0;
      fail_code_q  <= '0;
      req_valid_q  <= 1'b0;
      req_rw_q     <= HTIF_HOST_RW_READ;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      verdict_q    <= verdict_d;
      cap_q        <= cap_d;
      fail_code_q  <= fail_code_d;
      req_valid_q  <= req_valid_d;
      req_rw_q     <= req_rw_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  assign htif_pcr_req_valid  = req_valid_q;
  assign htif_pcr_req_rw     = req_rw_q;
  assign htif_pcr_req_addr   = CSR_ADDR_TO_HOST;
  assign htif_pcr_req_data   = '0;
  assign htif_pcr_resp_ready = resp_ready_q;
  assign done                = verdict_q.done;
  assign pass                = verdict_q.pass;
  assign fail                = verdict_q.fail;
  assign timeout             = verdict_q.timeout;
  assign fail_code           = fail_code_q;
  assign cycle_count         = cycle_cnt;

endmodule

// File: tb/tb_vscale_htif_host.sv
// Directed bench for vscale_htif_host: core PCR responder tasks plus hand-computed expectations.
module tb_vscale_htif_host;

  localparam logic [11:0] TO_HOST = 12'h780;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_rw;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        done, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nreads, nwrites, wr_bad, done_cyc;
  logic last_rw = 1'b0;

  vscale_htif_host #(.PCR_WIDTH(64), .POLL_GAP(8), .MAX_CYCLES(200)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .fail                (fail),
    .timeout             (timeout),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  always #5 clk = ~clk;

  // Edges since reset release, sampled at negedges.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Core model: accepts any request at once, answers reads with val once cyc >= sw_cyc.
  task automatic run_core(input logic [63:0] val, input int sw_cyc, input int until_cyc);
    nreads = 0; nwrites = 0; wr_bad = 0;
    while (!done && cyc < until_cyc) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (req_valid) begin
        req_ready = 1'b1;
        last_rw   = req_rw;
        if (req_rw) begin
          nwrites++;
          if (req_data !== 64'd0 || req_addr !== TO_HOST) wr_bad++;
        end else begin
          nreads++;
        end
      end else if (resp_ready) begin
        resp_valid = 1'b1;
        resp_data  = (!last_rw && cyc >= sw_cyc) ? val : 64'd0;
      end
      @(negedge clk);
    end
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    done_cyc   = cyc;
  endtask

  task automatic wait_req(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (req_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_verdict(input string tag, input logic [3:0] exp_dpft, input logic [30:0] exp_code);
    check({tag, "_verdict"}, {done, pass, fail, timeout}, exp_dpft);
    check({tag, "_fail_code"}, fail_code, exp_code);
  endtask

  initial begin
    bit got;
    int quiet;

    // Reset state
    apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_status", {done, pass, fail, timeout, req_valid, req_rw, resp_ready}, 7'd0);
    check("rst_code_cnt", {fail_code, cycle_count}, 63'd0);
    check("rst_addr", req_addr, TO_HOST);
    check("rst_data", req_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First read exactly POLL_GAP cycles after release
    repeat (7) @(negedge clk);
    check("first_rd_early", req_valid, 1'b0);
    @(negedge clk);
    check("first_rd_valid", {req_valid, req_rw, req_addr}, {1'b1, 1'b0, TO_HOST});
    check("first_rd_cycle", cycle_count, 32'd8);

    // Core always returns 0 -> timeout at edge 201 after 20 reads
    run_core(64'd0, 0, 400);
    check_verdict("tmo", 4'b1001, 31'd0);
    check("tmo_done_cyc", done_cyc, 201);
    check("tmo_nreads", nreads, 20);
    check("tmo_cycle_count", cycle_count, 32'd201);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_valid || resp_ready) quiet++;
    end
    check("tmo_quiet_after_done", quiet, 0);
    check("tmo_count_in_done", cycle_count, 32'd221);

    // to_host becomes 1 at cycle 50 -> pass after read at edge 58
    apply_reset();
    run_core(64'd1, 50, 400);
    check_verdict("pass50", 4'b1100, 31'd0);
    check("pass50_done_cyc", done_cyc, 62);
    check("pass50_rd_wr", {nreads[7:0], nwrites[7:0], wr_bad[7:0]}, {8'd6, 8'd1, 8'd0});
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_valid) quiet++;
    end
    check("pass50_no_more_req", quiet, 0);

    // to_host = 7 -> fail, code 3
    apply_reset();
    run_core(64'd7, 0, 400);
    check_verdict("fail7", 4'b1010, 31'd3);
    check("fail7_done_cyc", done_cyc, 12);
    check("fail7_rd_wr", {nreads[7:0], nwrites[7:0], wr_bad[7:0]}, {8'd1, 8'd1, 8'd0});

    // Upper bits only -> fail with code 0; low word 1 with upper junk -> pass
    apply_reset();
    run_core(64'h0000_0001_0000_0000, 0, 400);
    check_verdict("hi_only", 4'b1010, 31'd0);
    apply_reset();
    run_core(64'h0000_0005_0000_0001, 0, 400);
    check_verdict("hi_lo1", 4'b1100, 31'd0);

    // req_ready held low 5 cycles; response alongside acceptance is ignored
    apply_reset();
    wait_req(20, got);
    check("hold_got_req", got, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_stable", {req_valid, req_rw, req_addr}, {1'b1, 1'b0, TO_HOST});
      @(negedge clk);
    end
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 64'd7;
    @(negedge clk);
    req_ready  = 1'b0;
    check("hold_after_hs", {req_valid, resp_ready}, 2'b01);
    resp_data  = 64'd0;
    @(negedge clk);
    resp_valid = 1'b0;
    check("hold_back_to_gap", {req_valid, resp_ready, done}, 3'b000);
    repeat (7) @(negedge clk);
    check("hold_next_rd_early", req_valid, 1'b0);
    @(negedge clk);
    check("hold_next_rd", {req_valid, req_rw}, 2'b10);

    // Read stalled across MAX_CYCLES, returns 1 -> pass, no timeout
    apply_reset();
    run_core(64'd0, 0, 197);
    check("xing_reads_before", nreads, 19);
    wait_req(20, got);
    check("xing_got_req", got, 1'b1);
    while (cyc < 203) @(negedge clk);
    check("xing_still_req", {req_valid, req_rw}, 2'b10);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("xing_resp_rdy", resp_ready, 1'b1);
    resp_valid = 1'b1;
    resp_data  = 64'd1;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_data  = '0;
    run_core(64'd0, 0, 400);
    check_verdict("xing", 4'b1100, 31'd0);
    check("xing_writes", {nwrites[7:0], wr_bad[7:0]}, {8'd1, 8'd0});
    check("xing_done_cyc", done_cyc, 207);

    // Reset pulsed during WR_RESP with a response pending
    apply_reset();
    run_core(64'd1, 0, 11);
    check("rstmid_in_wr_resp", {resp_ready, req_valid, done}, 3'b100);
    resp_valid = 1'b1;
    resp_data  = 64'd1;
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_async", {done, pass, fail, timeout, req_valid, req_rw, resp_ready}, 7'd0);
    check("rstmid_cnt", cycle_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    check("rstmid_rd_early", {req_valid, resp_ready, done}, 3'b000);
    @(negedge clk);
    check("rstmid_first_rd", {req_valid, req_rw, resp_ready, done}, 4'b1000);
    resp_valid = 1'b0;
    resp_data  = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
